// File: rtl/shift_sub_divider_pkg.sv
// Shared types and sizing helpers for the shift/subtract restoring divider.
package shift_sub_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_N = 8;
    localparam int CNT_W = $clog2(DIV_N + 1);

    // Counter must hold the value N itself, hence N+1 states.
    function automatic int cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_sub_divider_rq_shift_reg.sv
// Combined {R,Q} register: parallel load, shift left by one, optional R replace and Q[0] insert.
module rq_shift_reg #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [2*N:0]   loadVal_i,
    input  logic           shift_i,
    input  logic           rReplace_i,
    input  logic [N:0]     rNew_i,
    input  logic           qBit_i,
    output logic [2*N:0]   rq_o
);

    logic [2*N:0] rq_q, rq_d;

    // Bits above R[N] are dropped on shift; R[N] is always 0 before a shift.
    always_comb begin
        rq_d = rq_q;
        if (load_i) begin
            rq_d = loadVal_i;
        end else if (shift_i) begin
            rq_d = {rq_q[2*N-1:0], 1'b0};
            if (rReplace_i) begin
                rq_d[2*N:N] = rNew_i;
            end
            rq_d[0] = qBit_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_q <= '0;
        end else begin
            rq_q <= rq_d;
        end
    end

    assign rq_o = rq_q;

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define SHIFT_SUB_DIVIDER_SIGNED_EN for two's-complement operands.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o
);

    localparam int CW = cntWidth(N);

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   divisor_q, divisor_d;
    logic           divZero_q, divZero_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic           rqLoad, rqShift;
    logic [2*N:0]   rqLoadVal, rq;
    logic [N:0]     rCur;
    logic [N-1:0]   qCur;
    logic [N+1:0]   shiftedR;
    logic [N:0]     diff;
    logic           ge;
    logic [N-1:0]   capDividend, capDivisor;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    logic           negQ_q, negQ_d, negR_q, negR_d;
    // The core only ever sees magnitudes; signs are reapplied when results are latched.
    assign capDividend = dividend_i[N-1] ? -dividend_i : dividend_i;
    assign capDivisor  = divisor_i[N-1]  ? -divisor_i  : divisor_i;
`else
    assign capDividend = dividend_i;
    assign capDivisor  = divisor_i;
`endif

    assign rCur     = rq[2*N:N];
    assign qCur     = rq[N-1:0];
    assign shiftedR = {rCur, qCur[N-1]};
    assign ge       = shiftedR >= {2'b00, divisor_q};
    assign diff     = shiftedR[N:0] - {1'b0, divisor_q};

    rq_shift_reg #(.N(N)) uRq (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rqLoad),
        .loadVal_i  (rqLoadVal),
        .shift_i    (rqShift),
        .rReplace_i (ge),
        .rNew_i     (diff),
        .qBit_i     (ge),
        .rq_o       (rq)
    );

    // Divide-by-zero runs one CALC cycle with the counter preset to N so its latency is 1.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        divZero_d   = divZero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rqLoad      = 1'b0;
        rqShift     = 1'b0;
        rqLoadVal   = {{(N+1){1'b0}}, capDividend};
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        negQ_d      = negQ_q;
        negR_d      = negR_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    rqLoad    = 1'b1;
                    state_d   = CALC;
                    divisor_d = capDivisor;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
                    negQ_d    = dividend_i[N-1] ^ divisor_i[N-1];
                    negR_d    = dividend_i[N-1];
`endif
                    if (divisor_i == '0) begin
                        divZero_d = 1'b1;
                        count_d   = CW'(N);
                        rqLoadVal = {{(N+1){1'b0}}, dividend_i};
                    end else begin
                        divZero_d = 1'b0;
                        count_d   = '0;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (count_q == CW'(N)) begin
                    state_d = DONE;
                    if (divZero_q) begin
                        quotient_d  = '1;
                        remainder_d = qCur;
                        dbz_d       = 1'b1;
                    end else begin
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
                        quotient_d  = negQ_q ? -qCur : qCur;
                        remainder_d = negR_q ? -rCur[N-1:0] : rCur[N-1:0];
`else
                        quotient_d  = qCur;
                        remainder_d = rCur[N-1:0];
`endif
                        dbz_d       = 1'b0;
                    end
                end else begin
                    rqShift = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            divZero_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            negQ_q      <= 1'b0;
            negR_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            divisor_q   <= divisor_d;
            divZero_q   <= divZero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            negQ_q      <= negQ_d;
            negR_q      <= negR_d;
`endif
        end
    end

    assign busy_o        = (state_q == CALC) && !divZero_q;
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider (N=8); signed cases under SHIFT_SUB_DIVIDER_SIGNED_EN.
module tb_shift_sub_divider;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] dividend_i;
    logic [7:0] divisor_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] quotient_o;
    logic [7:0] remainder_o;
    logic       div_by_zero_o;

    int errors = 0;
    int checks = 0;

    shift_sub_divider #(.N(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a start request that the next rising edge (edge 0) samples.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
    endtask

    // Returns the edge index (after edge 0) at which done is seen; 99 on timeout.
    task automatic waitDone(output int lat, output logic sawBusy, output logic overlap);
        lat = 99;
        sawBusy = 1'b0;
        overlap = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (busy_o) sawBusy = 1'b1;
            if (busy_o && done_o) overlap = 1'b1;
            if (done_o) begin
                lat = c - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
        #12;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done_o); end
        checks++; if (quotient_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_q got %0h want 0", quotient_o); end
        checks++; if (remainder_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_r got %0h want 0", remainder_o); end
        checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got %0b want 0", div_by_zero_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic sawBusy, overlap;
        applyStimulus(8'd100, 8'd7);
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL basic_latency got %0d want 9", lat); end
        checks++; if (sawBusy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %0b want 1", sawBusy); end
        checks++; if (overlap !== 1'b0) begin errors++; $display("[TB] FAIL basic_overlap got %0b want 0", overlap); end
        checks++; if (quotient_o !== 8'd14) begin errors++; $display("[TB] FAIL basic_q got %0d want 14", quotient_o); end
        checks++; if (remainder_o !== 8'd2) begin errors++; $display("[TB] FAIL basic_r got %0d want 2", remainder_o); end
        checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_dbz got %0b want 0", div_by_zero_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %0b want 0", done_o); end
        checks++; if (quotient_o !== 8'd14) begin errors++; $display("[TB] FAIL basic_q_hold got %0d want 14", quotient_o); end
    endtask

    task automatic test_back_to_back();
        int lat; logic sawBusy, overlap;
        applyStimulus(8'd255, 8'd1);
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL b2b_lat1 got %0d want 9", lat); end
        checks++; if (quotient_o !== 8'd255) begin errors++; $display("[TB] FAIL b2b_q1 got %0d want 255", quotient_o); end
        checks++; if (remainder_o !== 8'd0) begin errors++; $display("[TB] FAIL b2b_r1 got %0d want 0", remainder_o); end
        dividend_i = 8'd3;
        divisor_i  = 8'd10;
        start_i    = 1'b1;
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL b2b_lat2 got %0d want 9", lat); end
        checks++; if (quotient_o !== 8'd0) begin errors++; $display("[TB] FAIL b2b_q2 got %0d want 0", quotient_o); end
        checks++; if (remainder_o !== 8'd3) begin errors++; $display("[TB] FAIL b2b_r2 got %0d want 3", remainder_o); end
    endtask

    task automatic test_div_by_zero();
        int lat; logic sawBusy, overlap;
        applyStimulus(8'd5, 8'd0);
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL dbz_latency got %0d want 1", lat); end
        checks++; if (sawBusy !== 1'b0) begin errors++; $display("[TB] FAIL dbz_busy got %0b want 0", sawBusy); end
        checks++; if (quotient_o !== 8'hFF) begin errors++; $display("[TB] FAIL dbz_q got %0h want ff", quotient_o); end
        checks++; if (remainder_o !== 8'd5) begin errors++; $display("[TB] FAIL dbz_r got %0d want 5", remainder_o); end
        checks++; if (div_by_zero_o !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag got %0b want 1", div_by_zero_o); end
        @(negedge clk);
        checks++; if (div_by_zero_o !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag_hold got %0b want 1", div_by_zero_o); end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [7:0] expQ, expR;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        expQ = 8'hFA; expR = 8'hFE;
`else
        expQ = 8'd22; expR = 8'd2;
`endif
        applyStimulus(8'd200, 8'd9);
        lat = 99;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (c == 4) begin start_i = 1'b1; dividend_i = 8'd50; divisor_i = 8'd3; end
            if (c == 5) start_i = 1'b0;
            if (done_o) begin lat = c - 1; break; end
        end
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 9", lat); end
        checks++; if (quotient_o !== expQ) begin errors++; $display("[TB] FAIL ignore_q got %0h want %0h", quotient_o, expQ); end
        checks++; if (remainder_o !== expR) begin errors++; $display("[TB] FAIL ignore_r got %0h want %0h", remainder_o, expR); end
    endtask

    task automatic test_reset_midop();
        int lat; logic sawBusy, overlap, sawDone;
        applyStimulus(8'd200, 8'd9);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (quotient_o !== 8'h00) begin errors++; $display("[TB] FAIL midrst_q got %0h want 0", quotient_o); end
        checks++; if (remainder_o !== 8'h00) begin errors++; $display("[TB] FAIL midrst_r got %0h want 0", remainder_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %0b want 0", busy_o); end
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_o || busy_o) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midrst_abandon got %0b want 0", sawDone); end
        applyStimulus(8'd50, 8'd5);
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL midrst_lat got %0d want 9", lat); end
        checks++; if (quotient_o !== 8'd10) begin errors++; $display("[TB] FAIL midrst_q got %0d want 10", quotient_o); end
        checks++; if (remainder_o !== 8'd0) begin errors++; $display("[TB] FAIL midrst_r got %0d want 0", remainder_o); end
    endtask

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat; logic sawBusy, overlap;
        applyStimulus(8'h9C, 8'd7);
        waitDone(lat, sawBusy, overlap);
        checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL signed_lat got %0d want 9", lat); end
        checks++; if (quotient_o !== 8'hF2) begin errors++; $display("[TB] FAIL signed_q got %0h want f2", quotient_o); end
        checks++; if (remainder_o !== 8'hFE) begin errors++; $display("[TB] FAIL signed_r got %0h want fe", remainder_o); end
        applyStimulus(8'h80, 8'hFF);
        waitDone(lat, sawBusy, overlap);
        checks++; if (quotient_o !== 8'h80) begin errors++; $display("[TB] FAIL signed_wrap_q got %0h want 80", quotient_o); end
        checks++; if (remainder_o !== 8'h00) begin errors++; $display("[TB] FAIL signed_wrap_r got %0h want 0", remainder_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_start_ignored();
        test_reset_midop();
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
